spi_cfg_tx: RTL and testbench

Transmit end of the glitcher configuration link. Packs the glitch parameters (start, stop, clock count, enable) into the 16-bit configuration word and serialises it MSB-first onto the three-wire clear/SCK/SDI interface that loads the glitcher's 16-bit shift register. Sits in the host-side controller, clocked from MCLK, between the sweep/control logic and the DIL_11/12/13 pins of the glitcher device.

---
 rtl/cfg_link_pkg.sv | 39 +++
 rtl/spi_cfg_tx_if.sv | 27 ++
 rtl/cfg_halfbit_timer.sv | 39 +++
 rtl/spi_cfg_tx.sv | 128 ++++++++++++
 tb/tb_spi_cfg_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_link_pkg.sv
// Shared definitions for the glitcher configuration link: word field layout,
// transmitter state encoding and the word packing helper.
package cfg_link_pkg;

    localparam int unsigned GS_LSB = 0;
    localparam int unsigned GP_LSB = 4;
    localparam int unsigned CC_LSB = 8;
    localparam int unsigned EN_BIT = 15;
    localparam int unsigned WORD_W = 16;

    localparam int unsigned GS_W = 4;
    localparam int unsigned GP_W = 4;
    localparam int unsigned CC_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOW,
        HIGH,
        TAIL
    } state_t;

    // Assemble {enable, clkcnt, glitchstop, glitchstart} into the link word.
    function automatic logic [WORD_W-1:0] pack_cfg(
        input logic [GS_W-1:0] gs,
        input logic [GP_W-1:0] gp,
        input logic [CC_W-1:0] cc,
        input logic            en
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[GS_LSB +: GS_W]  = gs;
        w[GP_LSB +: GP_W]  = gp;
        w[CC_LSB +: CC_W]  = cc;
        w[EN_BIT]          = en;
        return w;
    endfunction

endpackage

// File: rtl/spi_cfg_tx_if.sv
// Host-side bundle for the configuration transmitter: request/config fields
// from the sweep logic, status back to it, and the three glitcher pins.
interface spi_cfg_tx_if;

    logic       start;
    logic [3:0] cfg_glitchstart;
    logic [3:0] cfg_glitchstop;
    logic [6:0] cfg_clkcnt;
    logic       cfg_glitchenable;

    logic       spi_clr_n;
    logic       spi_sck;
    logic       spi_sdi;
    logic       busy;
    logic       done;

    modport master (
        output start, cfg_glitchstart, cfg_glitchstop, cfg_clkcnt, cfg_glitchenable,
        input  spi_clr_n, spi_sck, spi_sdi, busy, done
    );

    modport slave (
        input  start, cfg_glitchstart, cfg_glitchstop, cfg_clkcnt, cfg_glitchenable,
        output spi_clr_n, spi_sck, spi_sdi, busy, done
    );

endinterface

// File: rtl/cfg_halfbit_timer.sv
// Half-period counter: counts 0..HALF-1 while running, flags the last count.
// Held at zero while load is high so every phase starts from a fresh count.
module cfg_halfbit_timer #(
    parameter int unsigned HALF = 2
) (
    input  logic MCLK,
    input  logic SPI_NRST,
    input  logic load,
    output logic wrap
);

    localparam int unsigned HC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);

    logic [HC_W-1:0] hc_q;
    logic [HC_W-1:0] hc_d;

    assign wrap = (hc_q == HC_LAST);

    // Next count: restart on load or at the end of a half period.
    always_comb begin
        hc_d = hc_q;
        if (load || wrap) begin
            hc_d = '0;
        end else begin
            hc_d = hc_q + HC_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge MCLK or negedge SPI_NRST) begin
        if (!SPI_NRST) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

endmodule

// File: rtl/spi_cfg_tx.sv
// Configuration link transmitter: latches the packed glitch word on start,
// pulses the far-end clear, then shifts 16 bits MSB-first on SCK/SDI.
module spi_cfg_tx
    import cfg_link_pkg::*;
#(
    parameter int unsigned HALF = 2
) (
    input  logic          MCLK,
    input  logic          SPI_NRST,
    spi_cfg_tx_if.slave   link
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [3:0]          bc_q, bc_d;
    logic                clr_n_q, clr_n_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hc_wrap;

    cfg_halfbit_timer #(
        .HALF (HALF)
    ) u_timer (
        .MCLK     (MCLK),
        .SPI_NRST (SPI_NRST),
        .load     (state_q == IDLE),
        .wrap     (hc_wrap)
    );

    // Next-state and next-output logic; every phase lasts one half period.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bc_d    = bc_q;
        clr_n_d = clr_n_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clr_n_d = 1'b1;
                sck_d   = 1'b0;
                sdi_d   = 1'b0;
                busy_d  = 1'b0;
                if (link.start) begin
                    sh_d    = pack_cfg(link.cfg_glitchstart, link.cfg_glitchstop,
                                       link.cfg_clkcnt, link.cfg_glitchenable);
                    busy_d  = 1'b1;
                    clr_n_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (hc_wrap) begin
                    clr_n_d = 1'b1;
                    sdi_d   = sh_q[WORD_W-1];
                    bc_d    = 4'd15;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (hc_wrap) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (hc_wrap) begin
                    sck_d = 1'b0;
                    if (bc_q == 4'd0) begin
                        state_d = TAIL;
                    end else begin
                        // SDI changes on the falling edge, giving a full half period of hold and setup.
                        sh_d    = {sh_q[WORD_W-2:0], 1'b0};
                        sdi_d   = sh_q[WORD_W-2];
                        bc_d    = bc_q - 4'd1;
                        state_d = LOW;
                    end
                end
            end
            TAIL: begin
                if (hc_wrap) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sdi_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and registered pin outputs.
    always_ff @(posedge MCLK or negedge SPI_NRST) begin
        if (!SPI_NRST) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bc_q    <= '0;
            clr_n_q <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            clr_n_q <= clr_n_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign link.spi_clr_n = clr_n_q;
    assign link.spi_sck   = sck_q;
    assign link.spi_sdi   = sdi_q;
    assign link.busy      = busy_q;
    assign link.done      = done_q;

endmodule

// File: tb/tb_spi_cfg_tx.sv
// Bench for spi_cfg_tx: three instances (HALF = 2, 1, 255) share clock and
// reset; a receiver model per instance captures the shifted word and a
// scoreboard compares it against hand-computed words on every done pulse.
module tb_spi_cfg_tx;
    import cfg_link_pkg::*;

    logic       MCLK = 1'b0;
    logic       SPI_NRST = 1'b0;
    logic       start_r [3];
    logic [3:0] gs_r, gp_r;
    logic [6:0] cc_r;
    logic       en_r;

    int checks = 0;
    int failures = 0;

    spi_cfg_tx_if bus0 ();
    spi_cfg_tx_if bus1 ();
    spi_cfg_tx_if bus2 ();

    spi_cfg_tx #(.HALF(2))   dut0 (.MCLK(MCLK), .SPI_NRST(SPI_NRST), .link(bus0.slave));
    spi_cfg_tx #(.HALF(1))   dut1 (.MCLK(MCLK), .SPI_NRST(SPI_NRST), .link(bus1.slave));
    spi_cfg_tx #(.HALF(255)) dut2 (.MCLK(MCLK), .SPI_NRST(SPI_NRST), .link(bus2.slave));

    assign bus0.start = start_r[0];
    assign bus1.start = start_r[1];
    assign bus2.start = start_r[2];
    assign {bus0.cfg_glitchenable, bus0.cfg_clkcnt, bus0.cfg_glitchstop, bus0.cfg_glitchstart} = {en_r, cc_r, gp_r, gs_r};
    assign {bus1.cfg_glitchenable, bus1.cfg_clkcnt, bus1.cfg_glitchstop, bus1.cfg_glitchstart} = {en_r, cc_r, gp_r, gs_r};
    assign {bus2.cfg_glitchenable, bus2.cfg_clkcnt, bus2.cfg_glitchstop, bus2.cfg_glitchstart} = {en_r, cc_r, gp_r, gs_r};

    logic clr_w [3], sck_w [3], sdi_w [3], busy_w [3], done_w [3];
    assign clr_w[0] = bus0.spi_clr_n;  assign clr_w[1] = bus1.spi_clr_n;  assign clr_w[2] = bus2.spi_clr_n;
    assign sck_w[0] = bus0.spi_sck;    assign sck_w[1] = bus1.spi_sck;    assign sck_w[2] = bus2.spi_sck;
    assign sdi_w[0] = bus0.spi_sdi;    assign sdi_w[1] = bus1.spi_sdi;    assign sdi_w[2] = bus2.spi_sdi;
    assign busy_w[0] = bus0.busy;      assign busy_w[1] = bus1.busy;      assign busy_w[2] = bus2.busy;
    assign done_w[0] = bus0.done;      assign done_w[1] = bus1.done;      assign done_w[2] = bus2.done;

    always #5 MCLK = ~MCLK;

    function automatic int half_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 255);
    endfunction

    task automatic check(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    // Scoreboard and receiver model state
    logic [15:0] exp_q [3][$];
    logic [15:0] rx [3];
    int          edges [3], bcnt [3], clr_lo [3], last_rise [3], done_cyc [3];
    logic        prev_sck [3], prev_clr [3], gap_en [3], done_seen [3];
    int          cyc = 0;

    // Receiver model and monitor, sampled on the falling MCLK edge.
    always @(negedge MCLK) begin
        logic [15:0] w;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!SPI_NRST) begin
                rx[k] = '0; edges[k] = 0; bcnt[k] = 0; clr_lo[k] = 0; last_rise[k] = -1;
                prev_sck[k] = 1'b0; prev_clr[k] = 1'b1;
            end else begin
                if (busy_w[k]) bcnt[k]++;
                if (!clr_w[k]) begin
                    if (prev_clr[k] && gap_en[k] && done_seen[k]) begin
                        check("clear_gap_after_done", k, cyc - done_cyc[k], 1);
                        done_seen[k] = 1'b0;
                    end
                    rx[k] = '0; edges[k] = 0; clr_lo[k]++;
                end else if (!prev_clr[k]) begin
                    check("clr_low_width", k, clr_lo[k], half_of(k));
                    clr_lo[k] = 0;
                end
                if (sck_w[k] && !prev_sck[k]) begin
                    rx[k] = {rx[k][14:0], sdi_w[k]};
                    edges[k]++;
                    if (last_rise[k] >= 0) check("sck_period", k, cyc - last_rise[k], 2 * half_of(k));
                    last_rise[k] = cyc;
                end
                if (done_w[k]) begin
                    check("done_expected", k, (exp_q[k].size() > 0) ? 1 : 0, 1);
                    if (exp_q[k].size() > 0) begin
                        w = exp_q[k].pop_front();
                        check("rx_word", k, rx[k], w);
                    end
                    check("sck_edges", k, edges[k], 16);
                    check("busy_len", k, bcnt[k], 34 * half_of(k));
                    check("busy_at_done", k, busy_w[k], 0);
                    if (gap_en[k]) begin
                        done_seen[k] = 1'b1;
                        done_cyc[k]  = cyc;
                    end
                    bcnt[k] = 0; last_rise[k] = -1;
                end
                prev_sck[k] = sck_w[k];
                prev_clr[k] = clr_w[k];
            end
        end
    end

    task automatic set_fields(input logic en, input logic [6:0] cc, input logic [3:0] gp, input logic [3:0] gs);
        en_r = en; cc_r = cc; gp_r = gp; gs_r = gs;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic pulse_start(input int k);
        start_r[k] = 1'b1;
        @(negedge MCLK);
        start_r[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while (!done_w[k] && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        check("done_within_budget", k, done_w[k], 1);
        @(negedge MCLK);
    endtask

    task automatic wait_busy(input int k, input int budget);
        int n;
        n = 0;
        while (!busy_w[k] && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        check("busy_within_budget", k, busy_w[k], 1);
    endtask

    initial begin
        int n;
        logic p;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0; gap_en[k] = 1'b0; done_seen[k] = 1'b0; done_cyc[k] = 0;
        end
        set_fields(1'b0, 7'h00, 4'h0, 4'h0);

        // Reset values
        idle(3);
        for (int k = 0; k < 3; k++)
            check("reset_outputs", k, {clr_w[k], sck_w[k], sdi_w[k], busy_w[k], done_w[k]}, 5'b10000);
        SPI_NRST = 1'b1;
        idle(3);
        for (int k = 0; k < 3; k++)
            check("idle_outputs", k, {clr_w[k], sck_w[k], sdi_w[k], busy_w[k], done_w[k]}, 5'b10000);

        // Packing helper against hand-packed vectors
        check("pack_a5a3", 0, pack_cfg(4'h3, 4'hA, 7'h25, 1'b1), 16'hA5A3);
        check("pack_8001", 0, pack_cfg(4'h1, 4'h0, 7'h00, 1'b1), 16'h8001);

        // HALF=2 basic frame
        set_fields(1'b1, 7'h25, 4'hA, 4'h3);
        exp_q[0].push_back(16'hA5A3);
        pulse_start(0);
        wait_done(0, 200);
        idle(4);

        // start pulses mid-frame are ignored
        set_fields(1'b0, 7'h12, 4'h3, 4'h4);
        exp_q[0].push_back(16'h1234);
        pulse_start(0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge MCLK);
            start_r[0] = (i == 10 || i == 30);
        end
        start_r[0] = 1'b0;
        wait_done(0, 200);
        idle(100);
        check("no_retrigger_busy", 0, busy_w[0], 0);

        // cfg inputs toggled every cycle after acceptance
        set_fields(1'b0, 7'h5A, 4'h5, 4'hA);
        exp_q[0].push_back(16'h5A5A);
        pulse_start(0);
        n = 0;
        while (!done_w[0] && n < 200) begin
            set_fields(~en_r, ~cc_r, ~gp_r, ~gs_r);
            @(negedge MCLK);
            n++;
        end
        wait_done(0, 10);
        idle(4);

        // HALF=1 back-to-back frames with start held high
        set_fields(1'b0, 7'h00, 4'h0, 4'h0);
        exp_q[1].push_back(16'h0000);
        exp_q[1].push_back(16'hFFFF);
        gap_en[1] = 1'b1;
        start_r[1] = 1'b1;
        wait_busy(1, 20);
        set_fields(1'b1, 7'h7F, 4'hF, 4'hF);
        wait_done(1, 100);
        start_r[1] = 1'b0;
        check("second_frame_busy", 1, busy_w[1], 1);
        wait_done(1, 100);
        gap_en[1] = 1'b0;
        idle(10);
        check("back_to_back_idle", 1, busy_w[1], 0);

        // Asynchronous reset after the 7th SCK rising edge
        set_fields(1'b0, 7'h3C, 4'h3, 4'hC);
        pulse_start(0);
        n = 0; p = 1'b0;
        for (int i = 0; i < 200 && n < 7; i++) begin
            @(negedge MCLK);
            if (bus0.spi_sck && !p) n++;
            p = bus0.spi_sck;
        end
        check("seven_edges_seen", 0, n, 7);
        #2 SPI_NRST = 1'b0;
        #1 check("async_reset_outputs", 0, {clr_w[0], sck_w[0], sdi_w[0], busy_w[0], done_w[0]}, 5'b10000);
        idle(2);
        SPI_NRST = 1'b1;
        idle(20);
        check("post_reset_idle", 0, busy_w[0], 0);
        set_fields(1'b1, 7'h00, 4'h0, 4'h1);
        exp_q[0].push_back(16'h8001);
        pulse_start(0);
        wait_done(0, 200);
        idle(4);

        // HALF=255 long frame
        set_fields(1'b0, 7'h0F, 4'h0, 4'hF);
        exp_q[2].push_back(16'h0F0F);
        pulse_start(2);
        wait_done(2, 9000);
        idle(10);

        for (int k = 0; k < 3; k++)
            check("scoreboard_drained", k, exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
